orv64_mul_iter: RTL and testbench

//  Parametrised iterative integer multiplier for the ORV64 EX stage; native RTL, no vendor IP.

---
 rtl/orv64_mul_iter_pkg.sv | 56 +++++
 rtl/orv64_mul_iter_if.sv | 29 ++
 rtl/orv64_mul_iter_radix_step.sv | 28 ++
 rtl/orv64_mul_iter.sv | 163 ++++++++++++++++
 tb/tb_orv64_mul_iter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/orv64_mul_iter_pkg.sv
// rtl/orv64_mul_iter_pkg.sv - types, parameters and operand-mode decode for the iterative multiplier
// Purpose: shared definitions for orv64_mul_iter, its interface and its testbench.
// Ports:   none (package).
package orv64_mul_iter_pkg;

   localparam int ORV64_XLEN            = 64;
   localparam int ORV64_MUL_RADIX_BITS  = 4;
   localparam int ORV64_MUL_REUSE_EN    = 1;
   // Worst case: one BUSY cycle per radix digit, plus FIXUP and the DONE cycle.
   localparam int ORV64_N_CYCLE_INT_MUL = ORV64_XLEN / ORV64_MUL_RADIX_BITS + 2;

   typedef enum logic [2:0] {
      MUL_L    = 3'd0,
      MUL_H    = 3'd1,
      MUL_HSU  = 3'd2,
      MUL_HUU  = 3'd3,
      MUL_W    = 3'd4,
      MUL_NONE = 3'd5
   } orv64_mul_type_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_FIXUP = 2'd2,
      S_DONE  = 2'd3
   } orv64_mul_iter_state_t;

   typedef struct packed {
      logic sign_a;
      logic sign_b;
      logic is_w;
   } mul_mode_t;

   // L, H and NONE all share the signed*signed mode, so they hit the same reuse entry.
   function automatic mul_mode_t decode_mul_type(input orv64_mul_type_t t);
      mul_mode_t m;
      m.sign_a = 1'b1;
      m.sign_b = 1'b1;
      m.is_w   = 1'b0;
      case (t)
         MUL_HSU: m.sign_b = 1'b0;
         MUL_HUU: begin
            m.sign_a = 1'b0;
            m.sign_b = 1'b0;
         end
         MUL_W: begin
            m.sign_a = 1'b0;
            m.sign_b = 1'b0;
            m.is_w   = 1'b1;
         end
         default: ;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/orv64_mul_iter_if.sv
// rtl/orv64_mul_iter_if.sv - request/response bundle between EX stage and the iterative multiplier
// Purpose: groups the multiplier handshake and operand/result buses.
// Ports:   master drives start_pulse, kill, mul_type, rs1, rs2; slave drives rdh, rdl, complete, busy.
interface orv64_mul_iter_if #(
   parameter int XLEN = 64
) ();
   import orv64_mul_iter_pkg::*;

   logic            start_pulse;
   logic            kill;
   orv64_mul_type_t mul_type;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic [XLEN-1:0] rdh;
   logic [XLEN-1:0] rdl;
   logic            complete;
   logic            busy;

   modport master (
      output start_pulse, kill, mul_type, rs1, rs2,
      input  rdh, rdl, complete, busy
   );

   modport slave (
      input  start_pulse, kill, mul_type, rs1, rs2,
      output rdh, rdl, complete, busy
   );

endinterface

// File: rtl/orv64_mul_iter_radix_step.sv
// rtl/orv64_mul_iter_radix_step.sv - one radix digit times the multiplicand, shifted and accumulated
// Purpose: combinational acc_o = acc_i + ((digit_i * mag_a_i) << (cnt_i * RADIX_BITS)).
// Ports:   acc_i/acc_o 2*XLEN accumulator, mag_a_i XLEN multiplicand magnitude,
//          digit_i RADIX_BITS multiplier digit, cnt_i digit index.
module orv64_mul_iter_radix_step #(
   parameter int XLEN       = 64,
   parameter int RADIX_BITS = 4,
   parameter int CNT_W      = 4
) (
   input  logic [2*XLEN-1:0]     acc_i,
   input  logic [XLEN-1:0]       mag_a_i,
   input  logic [RADIX_BITS-1:0] digit_i,
   input  logic [CNT_W-1:0]      cnt_i,
   output logic [2*XLEN-1:0]     acc_o
);

   localparam int SH_W = $clog2(2*XLEN);

   logic [SH_W-1:0]   shamt;
   logic [2*XLEN-1:0] pp;

   always_comb begin
      shamt = SH_W'(cnt_i) * SH_W'(RADIX_BITS);
      pp    = (2*XLEN)'(digit_i) * (2*XLEN)'(mag_a_i);
      acc_o = acc_i + (pp << shamt);
   end

endmodule

// File: rtl/orv64_mul_iter.sv
// rtl/orv64_mul_iter.sv - iterative radix-2^RADIX_BITS multiplier with early exit and operand reuse
// Purpose: EX-stage integer multiplier; magnitude multiply, sign fix-up, last-result reuse.
// Ports:   clk, rst (sync, active-high); mul_if (slave) carries start_pulse/kill/mul_type/rs1/rs2
//          in and rdh/rdl/complete/busy out.
module orv64_mul_iter
   import orv64_mul_iter_pkg::*;
#(
   parameter int XLEN       = ORV64_XLEN,
   parameter int RADIX_BITS = ORV64_MUL_RADIX_BITS,
   parameter int REUSE_EN   = ORV64_MUL_REUSE_EN
) (
   input  logic          clk,
   input  logic          rst,
   orv64_mul_iter_if.slave mul_if
);

   localparam int N_ITER   = XLEN / RADIX_BITS;
   localparam int N_ITER_W = 32 / RADIX_BITS;
   localparam int CNT_W    = (N_ITER > 1) ? $clog2(N_ITER) : 1;
   localparam int KEY_W    = 2*XLEN + 3;

   orv64_mul_iter_state_t state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   mag_a_q, mag_a_d, mplier_q, mplier_d;
   logic [XLEN-1:0]   rdh_q, rdh_d, rdl_q, rdl_d;
   logic [2*XLEN-1:0] acc_q, acc_d, acc_step, res;
   logic              neg_q, neg_d, w_q, w_d, reuse_vld_q, reuse_vld_d;
   logic [KEY_W-1:0]  op_key_q, op_key_d, reuse_key_q, reuse_key_d;

   mul_mode_t         req_mode;
   logic [XLEN-1:0]   req_a, req_b;
   logic              req_neg_a, req_neg_b;
   logic [KEY_W-1:0]  req_key;
   logic              start_ok, reuse_hit, iter_last;

   orv64_mul_iter_radix_step #(
      .XLEN       (XLEN),
      .RADIX_BITS (RADIX_BITS),
      .CNT_W      (CNT_W)
   ) u_step (
      .acc_i   (acc_q),
      .mag_a_i (mag_a_q),
      .digit_i (mplier_q[RADIX_BITS-1:0]),
      .cnt_i   (cnt_q),
      .acc_o   (acc_step)
   );

   // Request decode, reuse lookup, iteration exit and sign fix-up.
   always_comb begin
      req_mode  = decode_mul_type(mul_if.mul_type);
      req_a     = req_mode.is_w ? XLEN'(mul_if.rs1[31:0]) : mul_if.rs1;
      req_b     = req_mode.is_w ? XLEN'(mul_if.rs2[31:0]) : mul_if.rs2;
      req_neg_a = req_mode.sign_a & req_a[XLEN-1];
      req_neg_b = req_mode.sign_b & req_b[XLEN-1];
      req_key   = {mul_if.rs1, mul_if.rs2, req_mode.sign_a, req_mode.sign_b, req_mode.is_w};
      start_ok  = mul_if.start_pulse & ~mul_if.kill & ((state_q == S_IDLE) || (state_q == S_DONE));
      reuse_hit = (REUSE_EN != 0) & reuse_vld_q & (req_key == reuse_key_q);
      // Exit as soon as no multiplier bits remain after this digit.
      iter_last = ((mplier_q >> RADIX_BITS) == '0) ||
                  (cnt_q == (w_q ? CNT_W'(N_ITER_W-1) : CNT_W'(N_ITER-1)));
      res       = neg_q ? -acc_q : acc_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (mul_if.kill) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: if (mul_if.start_pulse) state_d = reuse_hit ? S_DONE : S_BUSY;
            S_BUSY:         if (iter_last) state_d = S_FIXUP;
            S_FIXUP:        state_d = S_DONE;
            default:        state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      mul_if.busy     = (state_q == S_BUSY) || (state_q == S_FIXUP);
      mul_if.complete = (state_q == S_DONE) & ~mul_if.start_pulse;
      mul_if.rdh      = rdh_q;
      mul_if.rdl      = rdl_q;
   end

   // rdh/rdl only change in FIXUP, so they always hold the reuse entry's result;
   // a reuse hit therefore just returns to DONE without touching them.
   always_comb begin
      cnt_d       = cnt_q;
      mag_a_d     = mag_a_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      neg_d       = neg_q;
      w_d         = w_q;
      op_key_d    = op_key_q;
      reuse_key_d = reuse_key_q;
      reuse_vld_d = reuse_vld_q;
      rdh_d       = rdh_q;
      rdl_d       = rdl_q;
      if (start_ok && !reuse_hit) begin
         cnt_d    = '0;
         acc_d    = '0;
         mag_a_d  = req_neg_a ? -req_a : req_a;
         mplier_d = req_neg_b ? -req_b : req_b;
         neg_d    = req_neg_a ^ req_neg_b;
         w_d      = req_mode.is_w;
         op_key_d = req_key;
      end else if ((state_q == S_BUSY) && !mul_if.kill) begin
         acc_d    = acc_step;
         mplier_d = mplier_q >> RADIX_BITS;
         cnt_d    = cnt_q + CNT_W'(1);
      end else if ((state_q == S_FIXUP) && !mul_if.kill) begin
         if (w_q) begin
            rdl_d = {{(XLEN-32){res[31]}}, res[31:0]};
            rdh_d = '0;
         end else begin
            rdl_d = res[XLEN-1:0];
            rdh_d = res[2*XLEN-1:XLEN];
         end
         reuse_key_d = op_key_q;
         reuse_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         mag_a_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         neg_q       <= 1'b0;
         w_q         <= 1'b0;
         op_key_q    <= '0;
         reuse_key_q <= '0;
         reuse_vld_q <= 1'b0;
         rdh_q       <= '0;
         rdl_q       <= '0;
      end else begin
         cnt_q       <= cnt_d;
         mag_a_q     <= mag_a_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         neg_q       <= neg_d;
         w_q         <= w_d;
         op_key_q    <= op_key_d;
         reuse_key_q <= reuse_key_d;
         reuse_vld_q <= reuse_vld_d;
         rdh_q       <= rdh_d;
         rdl_q       <= rdl_d;
      end
   end

   start_while_busy_a: assert property (@(posedge clk) disable iff (rst)
      !(mul_if.start_pulse && mul_if.busy));

endmodule

// File: tb/tb_orv64_mul_iter.sv
// tb/tb_orv64_mul_iter.sv - scoreboard bench for orv64_mul_iter
module tb_orv64_mul_iter;
   import orv64_mul_iter_pkg::*;

   localparam int XLEN = 64;
   localparam int R    = ORV64_MUL_RADIX_BITS;

   typedef struct {
      logic [63:0] h;
      logic [63:0] l;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   orv64_mul_iter_if #(.XLEN(XLEN)) mif ();

   orv64_mul_iter #(.XLEN(XLEN), .RADIX_BITS(R), .REUSE_EN(1)) dut (
      .clk    (clk),
      .rst    (rst),
      .mul_if (mif)
   );

   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   exp_t exp_q[$];

   bit           rv = 1'b0;
   logic [130:0] rkey = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain wide arithmetic on sign/zero-extended operands.
   function automatic void ref_mul(input orv64_mul_type_t t, input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] h, output logic [63:0] l, output int k,
                                   output logic [130:0] key);
      bit sa, sb, w;
      logic [127:0] ea, eb, p;
      logic [63:0]  p32, mb;
      int nbits;
      sa = (t == MUL_L) || (t == MUL_H) || (t == MUL_NONE) || (t == MUL_HSU);
      sb = (t == MUL_L) || (t == MUL_H) || (t == MUL_NONE);
      w  = (t == MUL_W);
      key = {a, b, sa, sb, w};
      if (w) begin
         p32 = 64'(a[31:0]) * 64'(b[31:0]);
         l = {{32{p32[31]}}, p32[31:0]};
         h = '0;
         mb = {32'b0, b[31:0]};
      end else begin
         ea = sa ? {{64{a[63]}}, a} : {64'b0, a};
         eb = sb ? {{64{b[63]}}, b} : {64'b0, b};
         p  = ea * eb;
         h  = p[127:64];
         l  = p[63:0];
         mb = (sb && b[63]) ? -b : b;
      end
      nbits = 0;
      for (int i = 0; i < 64; i++) if (mb[i]) nbits = i + 1;
      k = (nbits + R - 1) / R;
      if (k == 0) k = 1;
   endfunction

   // abort_at: cycle (relative to start) in which kill/rst is asserted; -1 = none, 0 = with start.
   task automatic issue(input orv64_mul_type_t t, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eh, input logic [63:0] el, input int elat,
                        input int abort_at, input bit abort_rst);
      logic [63:0]  dh, dl;
      int           dk;
      logic [130:0] key;
      bit           hit, completes;
      ref_mul(t, a, b, dh, dl, dk, key);
      hit       = rv && (key == rkey);
      completes = (abort_at < 0) || (abort_at >= elat);
      if (completes) exp_q.push_back('{eh, el, elat});
      mif.start_pulse = 1'b1;
      mif.mul_type    = t;
      mif.rs1         = a;
      mif.rs2         = b;
      if (abort_at == 0) mif.kill = 1'b1;
      tick();
      mif.start_pulse = 1'b0;
      mif.kill        = 1'b0;
      if (abort_at == 0) return;
      for (int c = 1; c <= elat; c++) begin
         if (c == abort_at) begin
            if (abort_rst) rst = 1'b1;
            else mif.kill = 1'b1;
            tick();
            rst      = 1'b0;
            mif.kill = 1'b0;
            break;
         end
         tick();
      end
      if (completes && !hit) begin
         rv   = 1'b1;
         rkey = key;
      end
      if (abort_at > 0 && abort_rst) rv = 1'b0;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   bit          armed = 1'b0, have_hold = 1'b0, kill_prev = 1'b0, rst_prev = 1'b0;
   int          start_cyc = 0;
   logic [63:0] hold_h, hold_l;

   always @(negedge clk) begin
      exp_t e;
      if (rst_prev) begin
         chk("rst_rdh", mif.rdh, 64'h0);
         chk("rst_rdl", mif.rdl, 64'h0);
         chk("rst_flags", {62'b0, mif.complete, mif.busy}, 64'h0);
      end else if (kill_prev) begin
         chk("kill_flags", {62'b0, mif.complete, mif.busy}, 64'h0);
      end
      chk("complete_and_busy", {63'b0, mif.complete & mif.busy}, 64'h0);
      if (mif.complete && armed) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_complete: got rdh=%h rdl=%h expected no result", mif.rdh, mif.rdl);
         end else begin
            e = exp_q.pop_front();
            chk("rdh", mif.rdh, e.h);
            chk("rdl", mif.rdl, e.l);
            chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
         end
         armed     = 1'b0;
         have_hold = 1'b1;
         hold_h    = mif.rdh;
         hold_l    = mif.rdl;
      end else if (mif.complete && have_hold) begin
         chk("rdh_stable", mif.rdh, hold_h);
         chk("rdl_stable", mif.rdl, hold_l);
      end else if (mif.complete) begin
         chk("stray_complete", 64'h1, 64'h0);
      end
      if (!mif.complete) have_hold = 1'b0;
      if (armed && (cyc - start_cyc > ORV64_N_CYCLE_INT_MUL + 4)) begin
         chk("timeout_complete", 64'h0, 64'h1);
         armed = 1'b0;
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (mif.kill || rst) armed = 1'b0;
      if (mif.start_pulse && !mif.busy && !mif.kill && !rst) begin
         armed     = 1'b1;
         start_cyc = cyc;
         have_hold = 1'b0;
      end
      kill_prev = mif.kill && !rst;
      rst_prev  = rst;
   end

   logic [63:0] ext [6] = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                            64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_8000_0000};

   initial begin
      orv64_mul_type_t t;
      logic [63:0]  a, b, pa, pb, eh, el;
      logic [130:0] key;
      int           k, lat, ab, r;
      bit           ar, hit;
      rst = 1'b1;
      mif.start_pulse = 1'b0;
      mif.kill        = 1'b0;
      mif.mul_type    = MUL_L;
      mif.rs1         = '0;
      mif.rs2         = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      issue(MUL_HUU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 18, -1, 1'b0);
      issue(MUL_L, 64'd3, -64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, 3, -1, 1'b0);
      issue(MUL_H, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
            64'h4000_0000_0000_0000, 64'h0, 18, -1, 1'b0);
      issue(MUL_L, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
            64'h4000_0000_0000_0000, 64'h0, 1, -1, 1'b0);
      issue(MUL_HSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 18, -1, 1'b0);
      issue(MUL_W, 64'h7FFF_FFFF, 64'h8000_0000, 64'h0, 64'hFFFF_FFFF_8000_0000, 10, -1, 1'b0);
      issue(MUL_HUU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 18, 5, 1'b0);
      issue(MUL_W, 64'h7FFF_FFFF, 64'h8000_0000, 64'h0, 64'hFFFF_FFFF_8000_0000, 1, -1, 1'b0);
      issue(MUL_L, 64'd12345, 64'd67890, 64'h0, 64'h0, 7, 4, 1'b1);
      issue(MUL_L, 64'd7, 64'd6, 64'h0, 64'd42, 3, -1, 1'b0);
      issue(MUL_W, 64'h7FFF_FFFF, 64'h8000_0000, 64'h0, 64'hFFFF_FFFF_8000_0000, 10, -1, 1'b0);

      pa = 64'd7;
      pb = 64'd6;
      for (int n = 0; n < 2500; n++) begin
         t = orv64_mul_type_t'($urandom_range(0, 5));
         case ($urandom_range(0, 5))
            0: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
            1: begin a = 64'($urandom_range(0, 255)); b = 64'($urandom_range(0, 255)); end
            2: begin a = -64'($urandom_range(0, 300)); b = -64'($urandom_range(0, 70000)); end
            3: begin a = ext[$urandom_range(0, 5)]; b = ext[$urandom_range(0, 5)]; end
            4: begin a = pa; b = pb; end
            default: begin a = {$urandom, $urandom}; b = 64'($urandom_range(0, 4095)); end
         endcase
         ref_mul(t, a, b, eh, el, k, key);
         hit = rv && (key == rkey);
         lat = hit ? 1 : k + 2;
         ab  = -1;
         ar  = 1'b0;
         r   = $urandom_range(0, 19);
         if (r == 0) ab = 0;
         else if (r <= 2) ab = $urandom_range(1, lat);
         else if (r == 3) begin ab = $urandom_range(1, lat); ar = 1'b1; end
         issue(t, a, b, eh, el, lat, ab, ar);
         pa = a;
         pb = b;
         repeat ($urandom_range(0, 2)) tick();
         if ($urandom_range(0, 15) == 0) begin
            mif.kill = 1'b1;
            tick();
            mif.kill = 1'b0;
         end
      end

      repeat (5) tick();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
